// File: rtl/fifo_burst_reader.sv
// Reads a burst of burst_len words from a first-word-fall-through FIFO and
// replays them as a valid/ready stream, marking the final word with m_last.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  rd,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  xfer;

  // A pop is only allowed when the output register is free or draining this cycle.
  assign rd = ~reset & (state_q == RUN) & (remaining_q != '0) & ~empty &
              (~m_valid_q | m_ready);
  assign xfer = m_valid_q & m_ready;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;

    if (rd) begin
      m_data_d    = r_data;
      m_valid_d   = 1'b1;
      m_last_d    = (remaining_q == LEN_WIDTH'(1));
      remaining_d = remaining_q - 1'b1;
    end else if (xfer) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            remaining_d = burst_len;
            state_d     = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (rd && (remaining_q == LEN_WIDTH'(1))) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (xfer && m_last_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // A held word must not change while the consumer is stalling it.
  assert property (@(posedge clk) disable iff (reset) rd |-> !empty);
  assert property (@(posedge clk) disable iff (reset)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_last)));

endmodule
